// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8002_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_BLOCKED = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-align a fetch address by clearing the two least significant bits.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, an output register
// and a one-entry skid buffer so a stalled decode never loses a returned word.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSN = DEF_NOP_INSN
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemAck,
  input  logic [XLEN-1:0] imemData,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectTarget,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] pcOut,
  output logic            insnValid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  fetch_entry_t    out_q, out_d;
  logic            out_valid_q, out_valid_d;
  fetch_entry_t    buf_q, buf_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    buf_d       = buf_q;

    // Consumption empties the output; a refill below may overwrite it.
    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
      out_d.insn  = NOP_INSN;
    end

    if (redirect) begin
      pc_d        = word_align(redirectTarget);
      out_valid_d = 1'b0;
      out_d.insn  = NOP_INSN;
      buf_d       = '0;
      case (state_q)
        ST_FETCH: begin
          if (!imemAck) begin
            req_addr_d = pc_q;
            state_d    = ST_DISCARD;
          end
        end
        ST_DISCARD: state_d = imemAck ? ST_FETCH : ST_DISCARD;
        default:    state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imemAck) begin
            pc_d = pc_q + XLEN'(4);
            if (!out_valid_q || !stall) begin
              out_d       = '{insn: imemData, pc: pc_q};
              out_valid_d = 1'b1;
            end else begin
              buf_d   = '{insn: imemData, pc: pc_q};
              state_d = ST_BLOCKED;
            end
          end
        end
        ST_BLOCKED: begin
          if (!stall) begin
            out_d       = buf_q;
            out_valid_d = 1'b1;
            state_d     = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (imemAck) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end

    // Request outputs are registered from the next state so they hold until ack.
    imem_req_d  = (state_d != ST_BLOCKED);
    imem_addr_d = (state_d == ST_DISCARD) ? req_addr_d : pc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      out_q       <= '{insn: NOP_INSN, pc: RESET_PC};
      out_valid_q <= 1'b0;
      buf_q       <= '0;
      imem_req_q  <= 1'b1;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      buf_q       <= buf_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imemReq   = imem_req_q;
  assign imemAddr  = imem_addr_q;
  assign insn      = out_q.insn;
  assign pcOut     = out_q.pc;
  assign insnValid = out_valid_q;

endmodule
